// File: rtl/rotate_commit.sv
// Rotation initiator: drives the combinational Rotate block, checks the candidate
// against board rows and walls, then commits or rejects. Optional wall kick: ROTATE_WALL_KICK_EN.
module rotate_commit #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int X_W     = 5,
  parameter int Y_W     = 6,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [0:15]        req_float,
  input  logic               req_dir,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  output logic [0:15]        rot_float,
  output logic               rot_dir,
  input  logic [0:15]        rot_new_float,
  output logic [ADDR_W-1:0]  row_addr,
  input  logic [BOARD_W-1:0] row_data,
  output logic               result_valid,
  output logic               result_ok,
  output logic [0:15]        result_float,
  output logic [1:0]         result_dx,
  output logic               busy
);

  localparam int CW = $clog2(BOARD_W);
  localparam logic signed [X_W:0] COL_LIM = (X_W+1)'(BOARD_W);
  localparam logic signed [Y_W:0] ROW_LIM = (Y_W+1)'(BOARD_H);

  typedef enum logic [2:0] {
    S_IDLE, S_ROT, S_READ0, S_READ1, S_READ2, S_READ3, S_WAIT, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [0:15]         r_rotFloat, r_cand, r_resFloat;
  logic                r_rotDir, r_coll, r_resValid, r_resOk;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_rowAddr;

  logic                w_accept, w_addrLoad, w_kick, w_chkEn, w_rowColl, w_passColl, w_cell;
  logic [1:0]          w_addrIdx, w_chkIdx, w_dx;
  logic signed [X_W:0] w_colBase, w_col;
  logic signed [Y_W:0] w_chkRow;

  function automatic logic signed [Y_W:0] rowOf(input logic [Y_W-1:0] y, input logic [1:0] k);
    return $signed({y[Y_W-1], y}) + $signed({{(Y_W-1){1'b0}}, k});
  endfunction

  // Rows above the top or below the bottom are never read meaningfully, so park the address at 0.
  function automatic logic [ADDR_W-1:0] clampAddr(input logic signed [Y_W:0] row);
    if (row[Y_W] || row >= ROW_LIM) return '0;
    return row[ADDR_W-1:0];
  endfunction

`ifdef ROTATE_WALL_KICK_EN
  logic [1:0] r_dx, r_pass, r_resDx;
  assign w_dx      = r_dx;
  assign result_dx = r_resDx;
`else
  assign w_dx      = 2'b00;
  assign result_dx = 2'b00;
`endif

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rot_float    = r_rotFloat;
  assign rot_dir      = r_rotDir;
  assign row_addr     = r_rowAddr;
  assign result_valid = r_resValid;
  assign result_ok    = r_resOk;
  assign result_float = r_resFloat;
  assign w_colBase    = $signed({r_x[X_W-1], r_x}) + $signed({{(X_W-1){w_dx[1]}}, w_dx});
  assign w_passColl   = r_coll | w_rowColl;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_addrLoad = 1'b0;
    w_addrIdx  = 2'd0;
    w_kick     = 1'b0;
    case (r_state)
      S_IDLE:  if (req_valid) begin w_accept = 1'b1; w_next = S_ROT; end
      S_ROT:   begin w_next = S_READ0; w_addrLoad = 1'b1; w_addrIdx = 2'd0; end
      S_READ0: begin w_next = S_READ1; w_addrLoad = 1'b1; w_addrIdx = 2'd1; end
      S_READ1: begin w_next = S_READ2; w_addrLoad = 1'b1; w_addrIdx = 2'd2; end
      S_READ2: begin w_next = S_READ3; w_addrLoad = 1'b1; w_addrIdx = 2'd3; end
      S_READ3: w_next = S_WAIT;
      S_WAIT: begin
        w_next = S_DONE;
`ifdef ROTATE_WALL_KICK_EN
        if (w_passColl && r_pass != 2'd2) begin
          w_next     = S_READ0;
          w_kick     = 1'b1;
          w_addrLoad = 1'b1;
        end
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row data lags its address by one cycle, so each state checks the previous row.
  always_comb begin
    w_chkEn  = 1'b1;
    w_chkIdx = 2'd0;
    case (r_state)
      S_READ1: w_chkIdx = 2'd0;
      S_READ2: w_chkIdx = 2'd1;
      S_READ3: w_chkIdx = 2'd2;
      S_WAIT:  w_chkIdx = 2'd3;
      default: w_chkEn  = 1'b0;
    endcase
    w_chkRow  = rowOf(r_y, w_chkIdx);
    w_rowColl = 1'b0;
    w_col     = '0;
    w_cell    = 1'b0;
    for (int c = 0; c < 4; c++) begin
      w_col  = w_colBase + (X_W+1)'(c);
      w_cell = r_cand[{w_chkIdx, 2'(c)}];
      if (w_cell) begin
        if (w_col[X_W] || w_col >= COL_LIM)                   w_rowColl = 1'b1;
        else if (w_chkRow >= ROW_LIM)                          w_rowColl = 1'b1;
        else if (!w_chkRow[Y_W] && row_data[w_col[CW-1:0]])   w_rowColl = 1'b1;
      end
    end
    if (!w_chkEn) w_rowColl = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rotFloat <= '0;
      r_rotDir   <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_cand     <= '0;
      r_coll     <= 1'b0;
      r_rowAddr  <= '0;
      r_resValid <= 1'b0;
      r_resOk    <= 1'b0;
      r_resFloat <= '0;
    end else begin
      r_resValid <= 1'b0;
      if (w_accept) begin
        r_rotFloat <= req_float;
        r_rotDir   <= req_dir;
        r_x        <= req_x;
        r_y        <= req_y;
        r_coll     <= 1'b0;
      end
      if (r_state == S_ROT) r_cand <= rot_new_float;
      if (w_addrLoad) r_rowAddr <= clampAddr(rowOf(r_y, w_addrIdx));
      if (w_kick)       r_coll <= 1'b0;
      else if (w_chkEn) r_coll <= r_coll | w_rowColl;
      if (w_next == S_DONE) begin
        r_resValid <= 1'b1;
        r_resOk    <= !w_passColl;
        r_resFloat <= w_passColl ? r_rotFloat : r_cand;
      end
    end
  end

`ifdef ROTATE_WALL_KICK_EN
  // Kick order after a colliding pass: shift left first, then right.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx    <= 2'b00;
      r_pass  <= 2'd0;
      r_resDx <= 2'b00;
    end else begin
      if (w_accept) begin
        r_dx   <= 2'b00;
        r_pass <= 2'd0;
      end else if (w_kick) begin
        r_pass <= r_pass + 2'd1;
        r_dx   <= (r_pass == 2'd0) ? 2'b11 : 2'b01;
      end
      if (w_next == S_DONE) r_resDx <= w_passColl ? 2'b00 : r_dx;
    end
  end
`endif

endmodule

// File: tb/tb_rotate_commit.sv
// Directed bench for rotate_commit with a Rotate stub, a registered board-row model
// and a queue of expected results.
module tb_rotate_commit;

  localparam int ADDR_W = 5;
`ifdef ROTATE_WALL_KICK_EN
  localparam bit KICK = 1'b1;
`else
  localparam bit KICK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_dir, rot_dir;
  logic [0:15]       req_float, rot_float, rot_new_float, result_float;
  logic [4:0]        req_x;
  logic [5:0]        req_y;
  logic [ADDR_W-1:0] row_addr;
  logic [9:0]        row_data;
  logic              result_valid, result_ok, busy;
  logic [1:0]        result_dx;

  logic [0:15] stubMain, stubAlt;
  logic [9:0]  board [0:19];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int acceptCyc = 0;

  typedef struct {
    logic        ok;
    logic [15:0] flt;
    logic [1:0]  dx;
    int          lat;
  } exp_t;
  exp_t sbQ[$];

  rotate_commit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_float(req_float), .req_dir(req_dir), .req_x(req_x), .req_y(req_y),
    .rot_float(rot_float), .rot_dir(rot_dir), .rot_new_float(rot_new_float),
    .row_addr(row_addr), .row_data(row_data), .result_valid(result_valid),
    .result_ok(result_ok), .result_float(result_float), .result_dx(result_dx),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) row_data <= (row_addr < 5'd20) ? board[row_addr] : 10'd0;
  assign rot_new_float = rot_dir ? stubAlt : stubMain;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] flt, input logic dir,
                               input int x, input int y, input logic eOk,
                               input logic [15:0] eFlt, input logic [1:0] eDx, input int eLat);
    int n = 0;
    exp_t e;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "-ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_float = flt;
    req_dir   = dir;
    req_x     = x[4:0];
    req_y     = y[5:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    acceptCyc = cyc;
    e.ok = eOk; e.flt = eFlt; e.dx = eDx; e.lat = eLat;
    sbQ.push_back(e);
    check({tag, "-rotFloat"}, rot_float, flt);
    check({tag, "-rotDir"}, rot_dir, dir);
    check({tag, "-busy"}, busy, 1);
  endtask

  task automatic checkOutput(input string tag, input bit chkAddr,
                             input int a0, input int a1, input int a2, input int a3);
    exp_t e;
    int k;
    logic [ADDR_W-1:0] seen [4];
    for (int i = 0; i < 4; i++) seen[i] = '0;
    e.ok = 1'b0; e.flt = '0; e.dx = '0; e.lat = 0;
    k = cyc - acceptCyc;
    while (!result_valid && k < 40) begin
      @(posedge clk); #1;
      k = cyc - acceptCyc;
      if (k >= 1 && k <= 4) seen[k-1] = row_addr;
    end
    check({tag, "-valid"}, result_valid, 1);
    check({tag, "-sbq"}, sbQ.size(), 1);
    if (sbQ.size() > 0) e = sbQ.pop_front();
    check({tag, "-lat"}, k, e.lat);
    check({tag, "-ok"}, result_ok, e.ok);
    check({tag, "-float"}, result_float, e.flt);
    check({tag, "-dx"}, result_dx, e.dx);
    check({tag, "-readyInDone"}, req_ready, 0);
    if (chkAddr) begin
      check({tag, "-addr0"}, seen[0], a0);
      check({tag, "-addr1"}, seen[1], a1);
      check({tag, "-addr2"}, seen[2], a2);
      check({tag, "-addr3"}, seen[3], a3);
    end
    @(posedge clk); #1;
    check({tag, "-validDrop"}, result_valid, 0);
    check({tag, "-readyBack"}, req_ready, 1);
    check({tag, "-okHold"}, result_ok, e.ok);
    check({tag, "-floatHold"}, result_float, e.flt);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 20; i++) board[i] = 10'd0;
    stubMain = 16'h0F00;
    stubAlt  = 16'h0000;

    // Reset with a simultaneous request: reset must win.
    rst = 1'b1; req_valid = 1'b1; req_float = 16'hFFFF; req_dir = 1'b1; req_x = 5'd3; req_y = 6'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst-ready", req_ready, 1);
    check("rst-busy", busy, 0);
    check("rst-valid", result_valid, 0);
    check("rst-ok", result_ok, 0);
    check("rst-dx", result_dx, 0);
    check("rst-float", result_float, 0);
    check("rst-rotFloat", rot_float, 0);
    check("rst-rotDir", rot_dir, 0);
    check("rst-addr", row_addr, 0);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic commit on empty board");
    applyStimulus("t1", 16'h4444, 1'b0, 3, 0, 1'b1, 16'h0F00, 2'b00, 6);
    checkOutput("t1", 1'b1, 0, 1, 2, 3);

    $display("[TB] right wall overrun");
    applyStimulus("t2", 16'h4444, 1'b0, 8, 0, 1'b0, 16'h4444, 2'b00, KICK ? 16 : 6);
    checkOutput("t2", 1'b1, 0, 1, 2, 3);

    $display("[TB] board cell blocks candidate");
    board[6] = 10'b0000100000;
    applyStimulus("t3", 16'h4444, 1'b0, 3, 5, 1'b0, 16'h4444, 2'b00, KICK ? 16 : 6);
    checkOutput("t3", 1'b1, 5, 6, 7, 8);
    board[6] = 10'd0;
    applyStimulus("t3b", 16'h4444, 1'b0, 3, 5, 1'b1, 16'h0F00, 2'b00, 6);
    checkOutput("t3b", 1'b0, 0, 0, 0, 0);

    $display("[TB] left wall, negative row");
    stubMain = 16'h0E00;
    applyStimulus("t4", 16'h4444, 1'b0, -1, -1, KICK, KICK ? 16'h0E00 : 16'h4444,
                  KICK ? 2'b01 : 2'b00, KICK ? 16 : 6);
    checkOutput("t4", 1'b1, 0, 0, 1, 2);

    $display("[TB] empty candidate");
    stubMain = 16'h0000;
    applyStimulus("t5", 16'h4444, 1'b0, -8, 18, 1'b1, 16'h0000, 2'b00, 6);
    checkOutput("t5", 1'b0, 0, 0, 0, 0);

    $display("[TB] direction 1 selects other stub output");
    stubAlt  = 16'h8000;
    board[2] = 10'b0000000001;
    applyStimulus("t6", 16'h1234, 1'b1, 0, 2, KICK, KICK ? 16'h8000 : 16'h1234,
                  KICK ? 2'b01 : 2'b00, KICK ? 16 : 6);
    checkOutput("t6", 1'b1, 2, 3, 4, 5);
    board[2] = 10'd0;

    $display("[TB] bottom row overrun with clamped address");
    stubMain = 16'h0001;
    applyStimulus("t7", 16'h4444, 1'b0, 0, 17, 1'b0, 16'h4444, 2'b00, KICK ? 16 : 6);
    checkOutput("t7", 1'b1, 17, 18, 19, 0);

    $display("[TB] request while busy is ignored");
    stubMain = 16'h0F00;
    applyStimulus("t8", 16'h4444, 1'b0, 3, 0, 1'b1, 16'h0F00, 2'b00, 6);
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_float = 16'hFFFF; req_x = 5'd0; req_y = 6'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("t8", 1'b0, 0, 0, 0, 0);
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (result_valid) pulses++; end
    check("t8-extraResults", pulses, 0);
    check("t8-idle", busy, 0);

    $display("[TB] reset during READ1");
    req_valid = 1'b1; req_float = 16'h4444; req_dir = 1'b0; req_x = 5'd3; req_y = 6'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("t9-busyBefore", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t9-ready", req_ready, 1);
    check("t9-busy", busy, 0);
    check("t9-float", result_float, 0);
    check("t9-ok", result_ok, 0);
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (result_valid) pulses++; end
    check("t9-noResult", pulses, 0);
    check("t9-sbqEmpty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
